// File: rtl/uart_ctrl.sv
// uart_ctrl: Wishbone master that configures a UART slave, then bridges its tx/rx FIFOs to byte streams.
module uart_ctrl #(
    parameter int CLOCK_FREQ_HZ  = 10000000,
    parameter int BAUD_RATE      = 115200,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    output logic [2:0]  ADR_O,
    output logic [31:0] DAT_O,
    input  logic [31:0] DAT_I,
    input  logic        ACK_I,
    input  logic        tx_valid,
    input  logic [7:0]  tx_byte,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_byte,
    input  logic        rx_ready,
    output logic        init_done,
    output logic        bus_err
);
    localparam int DIV_FULL = CLOCK_FREQ_HZ / BAUD_RATE - 1;
    localparam logic [15:0] DIV = 16'(DIV_FULL);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    typedef enum logic [2:0] {INIT_DIV, INIT_TX, INIT_RX, IDLE, TX_CHECK, TX_WRITE, RX_READ, GAP} state_t;
    state_t state, nxt;
    logic last_rx, pick_tx, req_we, unused;
    logic [2:0] req_adr;
    logic [31:0] req_dat;
    logic [7:0] cnt;
    // an RX request exists whenever the rx slot is empty; last_rx breaks ties round-robin
    assign pick_tx = tx_valid && (rx_valid || last_rx);
    assign tx_ready = STB_O && ACK_I && state == TX_WRITE;
    assign unused = ^DAT_I[30:8];
    always_comb begin
        req_adr = 3'd0;
        req_we = 1'b0;
        req_dat = '0;
        case (state)
            INIT_DIV: begin
                req_adr = 3'd6;
                req_we = 1'b1;
                req_dat = {16'd0, DIV};
            end
            INIT_TX: begin
                req_adr = 3'd2;
                req_we = 1'b1;
                req_dat = 32'd1;
            end
            INIT_RX: begin
                req_adr = 3'd3;
                req_we = 1'b1;
                req_dat = 32'd1;
            end
            TX_WRITE: begin
                req_we = 1'b1;
                req_dat = {24'd0, tx_byte};
            end
            RX_READ: req_adr = 3'd1;
            default: ;
        endcase
    end
    // bus states spend one cycle presenting the request (capturing tx_byte), then hold it until ACK or timeout
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state <= INIT_DIV;
            nxt <= INIT_DIV;
            last_rx <= 1'b1;
            cnt <= '0;
            CYC_O <= 1'b0;
            STB_O <= 1'b0;
            WE_O <= 1'b0;
            ADR_O <= '0;
            DAT_O <= '0;
            rx_valid <= 1'b0;
            rx_byte <= '0;
            init_done <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
            case (state)
                IDLE: if (tx_valid || !rx_valid) begin
                    state <= pick_tx ? TX_CHECK : RX_READ;
                    last_rx <= !pick_tx;
                end
                GAP: state <= nxt;
                default:
                    if (!STB_O) begin
                        CYC_O <= 1'b1;
                        STB_O <= 1'b1;
                        WE_O <= req_we;
                        ADR_O <= req_adr;
                        DAT_O <= req_dat;
                        cnt <= '0;
                    end else if (ACK_I || cnt == TO_LAST) begin
                        CYC_O <= 1'b0;
                        STB_O <= 1'b0;
                        state <= GAP;
                        nxt <= IDLE;
                        if (!ACK_I) begin
                            bus_err <= 1'b1;
                            if (!init_done)
                                nxt <= state;
                        end else
                            case (state)
                                INIT_DIV: nxt <= INIT_TX;
                                INIT_TX:  nxt <= INIT_RX;
                                INIT_RX:  init_done <= 1'b1;
                                TX_CHECK: if (!DAT_I[31]) nxt <= TX_WRITE;
                                RX_READ:  if (!DAT_I[31]) begin
                                    rx_byte <= DAT_I[7:0];
                                    rx_valid <= 1'b1;
                                end
                                default: ;
                            endcase
                    end else
                        cnt <= cnt + 8'd1;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: directed tests of uart_ctrl against a zero-wait Wishbone UART slave model.
module tb_uart_ctrl;
    logic CLK_I = 1'b0;
    logic RST_I = 1'b1;
    logic CYC_O, STB_O, WE_O, ACK_I;
    logic [2:0] ADR_O;
    logic [31:0] DAT_O, DAT_I;
    logic tx_valid = 1'b0;
    logic [7:0] tx_byte = 8'd0;
    logic tx_ready, rx_valid, init_done, bus_err;
    logic [7:0] rx_byte;
    logic rx_ready = 1'b0;
    logic no_ack_rd0 = 1'b0;
    logic rx_empty = 1'b1;
    logic [7:0] rx_data = 8'd0;
    int full_n = 0;
    int full_b = 0;
    int rd0p = 0;
    int checks = 0;
    int failures = 0;
    typedef struct {logic we; logic [2:0] adr; logic [31:0] dat; int cyc;} txn_t;
    txn_t log_q[$];
    int cyc = 0;
    int rd0 = 0, rd0_full = 0, wr0 = 0, rd1 = 0, tx_pulses = 0;
    logic [31:0] last_wr0 = 32'd0;
    bit early = 1'b0;
    int lb, rd0_b, rd0f_b, wr0_b, rd1_b, tp_b;

    uart_ctrl dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
        .ADR_O(ADR_O), .DAT_O(DAT_O), .DAT_I(DAT_I), .ACK_I(ACK_I),
        .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_ready(rx_ready),
        .init_done(init_done), .bus_err(bus_err)
    );

    always #5 CLK_I = ~CLK_I;

    // slave: acks in the same cycle; txdata reports full for the first full_n reads since full_b
    assign ACK_I = CYC_O && STB_O && !(no_ack_rd0 && ADR_O == 3'd0 && !WE_O);
    assign DAT_I = ADR_O == 3'd0 ? {(rd0p - full_b) < full_n, 31'd0} :
                   ADR_O == 3'd1 ? {rx_empty, 23'd0, rx_data} : 32'd0;

    always @(posedge CLK_I) begin
        cyc <= cyc + 1;
        if (CYC_O && STB_O && ACK_I && ADR_O == 3'd0 && !WE_O)
            rd0p <= rd0p + 1;
    end

    always @(negedge CLK_I) begin
        if (!init_done && (tx_ready || rx_valid))
            early = 1'b1;
        if (tx_ready)
            tx_pulses++;
        if (CYC_O && STB_O && ACK_I) begin
            log_q.push_back('{WE_O, ADR_O, DAT_O, cyc});
            if (ADR_O == 3'd0 && !WE_O) begin
                rd0++;
                if (DAT_I[31]) rd0_full++;
            end
            if (ADR_O == 3'd0 && WE_O) begin
                wr0++;
                last_wr0 = DAT_O;
            end
            if (ADR_O == 3'd1 && !WE_O)
                rd1++;
        end
    end

    task automatic do_reset;
        @(posedge CLK_I);
        #1 RST_I = 1'b1;
        repeat (2) @(posedge CLK_I);
        #1;
        lb = log_q.size();
        rd0_b = rd0;
        rd0f_b = rd0_full;
        wr0_b = wr0;
        rd1_b = rd1;
        tp_b = tx_pulses;
        full_b = rd0p;
        RST_I = 1'b0;
    endtask

    task automatic wait_init(output bit ok, output int c);
        ok = 1'b0;
        c = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK_I);
            if (init_done) begin
                ok = 1'b1;
                c = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset;
        tx_valid = 1'b1;
        rx_ready = 1'b1;
        repeat (2) @(negedge CLK_I);
        checks++;
        if ({CYC_O, STB_O, WE_O, ADR_O, DAT_O, tx_ready, rx_valid, rx_byte, init_done, bus_err} !== 50'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b %b %b %h %h %b %b %h %b %b, want all 0",
                     CYC_O, STB_O, WE_O, ADR_O, DAT_O, tx_ready, rx_valid, rx_byte, init_done, bus_err);
        end
        tx_valid = 1'b0;
        rx_ready = 1'b0;
    endtask

    task automatic test_init;
        bit ok;
        int c;
        tx_valid = 1'b0;
        rx_empty = 1'b1;
        full_n = 0;
        do_reset();
        wait_init(ok, c);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL init_timeout: init_done never rose within 100 cycles");
        end
        checks++;
        if (log_q.size() < lb + 3) begin
            failures++;
            $display("FAIL init_count: got %0d transactions, want >= 3", log_q.size() - lb);
        end else begin
            checks++;
            if ({log_q[lb].we, log_q[lb].adr, log_q[lb].dat} !== {1'b1, 3'd6, 32'h55}) begin
                failures++;
                $display("FAIL init_div: got we=%b adr=%0d dat=%h, want we=1 adr=6 dat=00000055",
                         log_q[lb].we, log_q[lb].adr, log_q[lb].dat);
            end
            checks++;
            if ({log_q[lb+1].we, log_q[lb+1].adr, log_q[lb+1].dat} !== {1'b1, 3'd2, 32'h1}) begin
                failures++;
                $display("FAIL init_tx: got we=%b adr=%0d dat=%h, want we=1 adr=2 dat=00000001",
                         log_q[lb+1].we, log_q[lb+1].adr, log_q[lb+1].dat);
            end
            checks++;
            if ({log_q[lb+2].we, log_q[lb+2].adr, log_q[lb+2].dat} !== {1'b1, 3'd3, 32'h1}) begin
                failures++;
                $display("FAIL init_rx: got we=%b adr=%0d dat=%h, want we=1 adr=3 dat=00000001",
                         log_q[lb+2].we, log_q[lb+2].adr, log_q[lb+2].dat);
            end
            checks++;
            if (log_q[lb+1].cyc - log_q[lb].cyc < 2 || log_q[lb+2].cyc - log_q[lb+1].cyc < 2) begin
                failures++;
                $display("FAIL init_gap: ack cycles %0d %0d %0d, want spacing >= 2",
                         log_q[lb].cyc, log_q[lb+1].cyc, log_q[lb+2].cyc);
            end
            checks++;
            if (c !== log_q[lb+2].cyc + 1) begin
                failures++;
                $display("FAIL init_done_cycle: got cycle %0d, want %0d", c, log_q[lb+2].cyc + 1);
            end
        end
        checks++;
        if (bus_err !== 1'b0) begin
            failures++;
            $display("FAIL init_bus_err: got %b, want 0", bus_err);
        end
    endtask

    // single byte, with tx_valid dropped right after the status read
    task automatic test_tx;
        bit ok, seen;
        int c;
        tx_valid = 1'b1;
        tx_byte = 8'h41;
        rx_empty = 1'b1;
        full_n = 0;
        do_reset();
        wait_init(ok, c);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK_I);
            if (CYC_O && STB_O && ACK_I && ADR_O == 3'd0 && !WE_O) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!(ok && seen)) begin
            failures++;
            $display("FAIL tx_check_seen: init=%b read=%b, want both 1", ok, seen);
        end
        @(posedge CLK_I);
        #1 tx_valid = 1'b0;
        repeat (30) @(negedge CLK_I);
        checks++;
        if (log_q.size() < lb + 4 || {log_q[lb+3].we, log_q[lb+3].adr} !== {1'b0, 3'd0}) begin
            failures++;
            $display("FAIL tx_first: first post-init transaction is not a read of ADR0 (log size %0d)", log_q.size() - lb);
        end
        checks++;
        if (rd0 - rd0_b !== 1 || wr0 - wr0_b !== 1) begin
            failures++;
            $display("FAIL tx_counts: got reads=%0d writes=%0d, want 1 and 1", rd0 - rd0_b, wr0 - wr0_b);
        end
        checks++;
        if (last_wr0 !== 32'h41) begin
            failures++;
            $display("FAIL tx_data: got %h, want 00000041", last_wr0);
        end
        checks++;
        if (tx_pulses - tp_b !== 1) begin
            failures++;
            $display("FAIL tx_ready_pulses: got %0d, want 1", tx_pulses - tp_b);
        end
    endtask

    task automatic test_tx_full;
        bit ok, seen;
        int c;
        tx_valid = 1'b0;
        rx_empty = 1'b0;
        rx_data = 8'h33;
        rx_ready = 1'b0;
        full_n = 3;
        do_reset();
        wait_init(ok, c);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK_I);
            if (rx_valid) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!(ok && seen)) begin
            failures++;
            $display("FAIL full_rx_fill: init=%b rx_valid=%b, want both 1", ok, seen);
        end
        @(posedge CLK_I);
        #1;
        rd1_b = rd1;
        tx_valid = 1'b1;
        tx_byte = 8'h7E;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK_I);
            if (tx_ready) begin
                seen = 1'b1;
                break;
            end
        end
        @(posedge CLK_I);
        #1 tx_valid = 1'b0;
        repeat (10) @(negedge CLK_I);
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL full_tx_ready: no tx_ready within 200 cycles");
        end
        checks++;
        if (rd0_full - rd0f_b !== 3 || wr0 - wr0_b !== 1) begin
            failures++;
            $display("FAIL full_counts: got full_reads=%0d writes=%0d, want 3 and 1", rd0_full - rd0f_b, wr0 - wr0_b);
        end
        checks++;
        if (tx_pulses - tp_b !== 1 || last_wr0 !== 32'h7E) begin
            failures++;
            $display("FAIL full_pulse_data: got pulses=%0d data=%h, want 1 and 0000007e", tx_pulses - tp_b, last_wr0);
        end
        checks++;
        if (rd1 - rd1_b !== 0 || rx_valid !== 1'b1 || rx_byte !== 8'h33) begin
            failures++;
            $display("FAIL full_rx_slot: got extra_rd1=%0d rx_valid=%b rx_byte=%h, want 0 1 33", rd1 - rd1_b, rx_valid, rx_byte);
        end
    endtask

    task automatic test_rx_hold;
        bit ok, seen;
        int c, bad;
        tx_valid = 1'b1;
        tx_byte = 8'h11;
        rx_empty = 1'b0;
        rx_data = 8'h5A;
        rx_ready = 1'b0;
        full_n = 0;
        do_reset();
        wait_init(ok, c);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK_I);
            if (rx_valid) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!(ok && seen)) begin
            failures++;
            $display("FAIL rx_arrive: init=%b rx_valid=%b, want both 1", ok, seen);
        end
        @(posedge CLK_I);
        #1;
        rd1_b = rd1;
        wr0_b = wr0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK_I);
            if (rx_valid !== 1'b1 || rx_byte !== 8'h5A) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL rx_hold: %0d of 10 cycles lost rx_valid/rx_byte (now %b %h), want 1 5a", bad, rx_valid, rx_byte);
        end
        checks++;
        if (rd1 - rd1_b !== 0 || wr0 - wr0_b < 1) begin
            failures++;
            $display("FAIL rx_hold_bus: got rd1=%0d tx_writes=%0d, want 0 and >=1", rd1 - rd1_b, wr0 - wr0_b);
        end
        @(posedge CLK_I);
        #1 rx_ready = 1'b1;
        @(posedge CLK_I);
        #1 rx_ready = 1'b0;
        @(negedge CLK_I);
        checks++;
        if (rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL rx_consume: got rx_valid=%b, want 0", rx_valid);
        end
        tx_valid = 1'b0;
    endtask

    task automatic test_round_robin;
        bit ok;
        int c;
        logic [2:0] ea [6] = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd1};
        logic ew [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tx_valid = 1'b1;
        tx_byte = 8'h22;
        rx_empty = 1'b1;
        full_n = 0;
        do_reset();
        wait_init(ok, c);
        repeat (60) @(negedge CLK_I);
        checks++;
        if (log_q.size() < lb + 9) begin
            failures++;
            $display("FAIL rr_count: got %0d transactions, want >= 9", log_q.size() - lb);
        end else
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (log_q[lb+3+k].adr !== ea[k] || log_q[lb+3+k].we !== ew[k]) begin
                    failures++;
                    $display("FAIL rr_seq%0d: got adr=%0d we=%b, want adr=%0d we=%b",
                             k, log_q[lb+3+k].adr, log_q[lb+3+k].we, ea[k], ew[k]);
                end
            end
        tx_valid = 1'b0;
    endtask

    task automatic test_timeout;
        bit ok, seen;
        int c, hi;
        tx_valid = 1'b1;
        tx_byte = 8'h55;
        rx_empty = 1'b1;
        full_n = 0;
        no_ack_rd0 = 1'b1;
        do_reset();
        wait_init(ok, c);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK_I);
            if (STB_O && ADR_O == 3'd0 && !WE_O) begin
                seen = 1'b1;
                break;
            end
        end
        hi = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK_I);
            if (STB_O) hi++;
            else break;
        end
        checks++;
        if (!(ok && seen) || hi !== 255) begin
            failures++;
            $display("FAIL to_length: init=%b seen=%b stb_cycles=%0d, want 1 1 255", ok, seen, hi);
        end
        checks++;
        if (bus_err !== 1'b1 || tx_pulses - tp_b !== 0 || init_done !== 1'b1) begin
            failures++;
            $display("FAIL to_flags: got bus_err=%b pulses=%0d init_done=%b, want 1 0 1", bus_err, tx_pulses - tp_b, init_done);
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK_I);
            if (STB_O) break;
        end
        #1 RST_I = 1'b1;
        #1;
        checks++;
        if ({CYC_O, STB_O, bus_err, init_done} !== 4'b0000) begin
            failures++;
            $display("FAIL to_async_reset: got cyc=%b stb=%b bus_err=%b init_done=%b, want 0 0 0 0", CYC_O, STB_O, bus_err, init_done);
        end
        no_ack_rd0 = 1'b0;
        tx_valid = 1'b0;
        @(posedge CLK_I);
        #1;
        lb = log_q.size();
        RST_I = 1'b0;
        wait_init(ok, c);
        checks++;
        if (!ok || log_q.size() <= lb || {log_q[lb].we, log_q[lb].adr, log_q[lb].dat} !== {1'b1, 3'd6, 32'h55}) begin
            failures++;
            $display("FAIL to_restart: init=%b log=%0d, want init_done and first write ADR6=00000055", ok, log_q.size() - lb);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_tx();
        test_tx_full();
        test_rx_hold();
        test_round_robin();
        test_timeout();
        checks++;
        if (early !== 1'b0) begin
            failures++;
            $display("FAIL early_stream: tx_ready or rx_valid seen with init_done=0");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
